scan_bist_ctrl: RTL and testbench
=================================

Name: scan_bist_ctrl

Overview:
- Parametrised on-chip scan BIST sequencer for scan-inserted ISCAS-style cores such as the s9234_scan family.
- Generates pseudo-random scan-in data from an LFSR and drives scan enable across NUM_CHAINS chains.
- Sequences shift, capture and unload phases, and compacts scan-out data in a MISR.
- Compares the final signature with a golden value, replacing the per-cycle output-XOR bench compare with a self-contained pass/fail.

Parameters:
- NUM_CHAINS, 4, number of parallel scan chains; 1..LFSR_W and 1..MISR_W.
- CHAIN_LEN, 64, flops in the longest chain (shift cycles per load); >=1.
- NUM_PATTERNS, 1024, capture cycles per run; >=1.
- LFSR_W, 32, LFSR width.
- LFSR_POLY, 32'h80200003, Galois feedback mask for the LFSR.
- LFSR_SEED, 32'h00000001, LFSR value after reset and at start; must be non-zero.
- MISR_W, 32, MISR width.
- MISR_POLY, 32'h04C11DB7, Galois feedback mask for the MISR.
- GOLDEN_SIG, 0, expected final MISR value.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  run request, level-sampled in IDLE.
- test_se  out  1  scan enable to the core.
- scan_in  out  NUM_CHAINS  serial data into chain heads.
- scan_out  in  NUM_CHAINS  serial data from chain tails.
- busy  out  1  run in progress.
- done  out  1  run complete; held in DONE.
- pass  out  1  signature == GOLDEN_SIG; valid when done=1.
- signature  out  MISR_W  current MISR contents.
- pattern_cnt  out  clog2(NUM_PATTERNS+1)  captures completed.

Behaviour:
- Reset values:
  - All outputs 0.
  - lfsr = LFSR_SEED, misr = 0, state = IDLE.
  - Reset takes priority in any state, including mid-run. test_se drops to 0 on the next edge.
- All outputs are registered. test_se and scan_in change only on the CK rising edge.
- IDLE:
  - start=1 → SHIFT next cycle.
  - On this transition: lfsr = LFSR_SEED, misr = 0, pattern_cnt = 0, first_load = 1, shift_cnt = 0, busy = 1.
- SHIFT:
  - test_se = 1.
  - Each cycle: scan_in = lfsr[NUM_CHAINS-1:0], then lfsr advances one Galois step: lfsr = {lfsr[W-2:0],0} ^ (lfsr[W-1] ? LFSR_POLY : 0).
  - If first_load = 0, the MISR compacts scan_out in the same cycle: misr = {misr[M-2:0],0} ^ (misr[M-1] ? MISR_POLY : 0) ^ zero_extend(scan_out).
  - After CHAIN_LEN cycles → CAPTURE, and first_load clears.
- CAPTURE:
  - Exactly 1 cycle, test_se = 0, scan_in = 0.
  - pattern_cnt increments.
  - If pattern_cnt reaches NUM_PATTERNS → UNLOAD, else → SHIFT.
- UNLOAD:
  - CHAIN_LEN cycles, test_se = 1, scan_in = 0.
  - LFSR frozen; MISR compacts every cycle.
  - Then → DONE.
- DONE:
  - busy = 0, done = 1, pass = (misr == GOLDEN_SIG).
  - signature is frozen.
  - Stays in DONE while start = 1. start = 0 → IDLE with done cleared; pass and signature keep their values until the next start.
- Timing:
  - Total busy cycles = NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN.
  - done rises on the cycle after the last UNLOAD shift.
- Boundary rules:
  - start while busy is ignored.
  - start held high through DONE does not retrigger; a falling edge to IDLE is required.
  - scan_out is not sampled during the first load (core power-up state is unknown) or during CAPTURE.
  - Counters must not wrap: shift_cnt is sized clog2(CHAIN_LEN+1), pattern_cnt saturates at NUM_PATTERNS.
  - scan_out bits are XORed into misr bits [NUM_CHAINS-1:0] only.

Test Plan:
1. NUM_CHAINS=2, CHAIN_LEN=4, NUM_PATTERNS=3. Pulse start → busy high for exactly 19 cycles. test_se pattern is 1111 0 1111 0 1111 0 1111. done=1 on cycle 20. pattern_cnt=3.
2. Same configuration, seed 1, scan_out looped through a 4-deep shift-register model of the chains → signature equals the bench's bit-accurate LFSR/MISR model. With GOLDEN_SIG set to that value, pass=1.
3. Same run with a single scan_out bit forced 1 on pattern 2, shift 3 → signature differs from the golden value, pass=0, done=1.
4. Assert RST on cycle 7 of a run → on the next edge test_se=0, busy=0, pattern_cnt=0, state IDLE. A new start reproduces the same signature as test 2.
5. Pulse start again mid-run, then hold start high through DONE → no restart. done stays 1 until start=0, then returns to IDLE with done=0.
6. Default parameters, scan_out tied to 0 → no MISR activity (misr stays 0), so signature=0 and pass=1 for GOLDEN_SIG=0. Busy length is 1024*65+64 = 66624 cycles.

Source files
------------

// File: rtl/scan_bist_ctrl.sv
// Scan BIST sequencer: LFSR-driven scan loads, capture pulses, MISR compaction of
// the unloaded responses, and a final compare against a golden signature.
module scan_bist_ctrl #(
    parameter int                NUM_CHAINS   = 4,
    parameter int                CHAIN_LEN    = 64,
    parameter int                NUM_PATTERNS = 1024,
    parameter int                LFSR_W       = 32,
    parameter logic [LFSR_W-1:0] LFSR_POLY    = 32'h80200003,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 32'h00000001,
    parameter int                MISR_W       = 32,
    parameter logic [MISR_W-1:0] MISR_POLY    = 32'h04C11DB7,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic                                    CK,
    input  logic                                    RST,
    input  logic                                    start,
    output logic                                    test_se,
    output logic [NUM_CHAINS-1:0]                   scan_in,
    input  logic [NUM_CHAINS-1:0]                   scan_out,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    pass,
    output logic [MISR_W-1:0]                       signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]       pattern_cnt
);
    localparam int SCW = $clog2(CHAIN_LEN + 1);
    localparam int PCW = $clog2(NUM_PATTERNS + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_src, lfsr_adv;
    logic [MISR_W-1:0] misr, misr_nxt;
    logic [SCW-1:0]    shift_cnt;
    logic              first_load, misr_en, shift_last;

    assign signature  = misr;
    assign shift_last = (shift_cnt == SCW'(CHAIN_LEN - 1));
    // lfsr always holds the value to present on the next shift cycle
    assign lfsr_adv   = {lfsr_src[LFSR_W-2:0], 1'b0} ^ (lfsr_src[LFSR_W-1] ? LFSR_POLY : '0);

    always_ff @(posedge CK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        misr_en   = 1'b0;
        lfsr_src  = (state == IDLE) ? LFSR_SEED : lfsr;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT: begin
                misr_en = !first_load;
                if (shift_last) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = (pattern_cnt >= PCW'(NUM_PATTERNS - 1)) ? UNLOAD : SHIFT;
            UNLOAD: begin
                misr_en = 1'b1;
                if (shift_last) state_nxt = DONE;
            end
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        misr_nxt = misr;
        if (misr_en)
            misr_nxt = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0)
                       ^ MISR_W'(scan_out);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            lfsr        <= LFSR_SEED;
            misr        <= '0;
            shift_cnt   <= '0;
            pattern_cnt <= '0;
            first_load  <= 1'b0;
            test_se     <= 1'b0;
            scan_in     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            busy    <= (state_nxt == SHIFT) || (state_nxt == CAPTURE) || (state_nxt == UNLOAD);
            test_se <= (state_nxt == SHIFT) || (state_nxt == UNLOAD);
            done    <= (state_nxt == DONE);
            scan_in <= (state_nxt == SHIFT) ? lfsr_src[NUM_CHAINS-1:0] : '0;
            if (state_nxt == SHIFT) lfsr <= lfsr_adv;
            misr <= misr_nxt;
            if (state == SHIFT || state == UNLOAD)
                shift_cnt <= shift_last ? '0 : shift_cnt + SCW'(1);
            if (state == SHIFT && shift_last) first_load <= 1'b0;
            if (state == CAPTURE && pattern_cnt != PCW'(NUM_PATTERNS))
                pattern_cnt <= pattern_cnt + PCW'(1);
            if (state == UNLOAD && shift_last) pass <= (misr_nxt == GOLDEN_SIG);
            // first load shifts against unknown core state, so it is not compacted
            if (state == IDLE && start) begin
                misr        <= '0;
                pattern_cnt <= '0;
                shift_cnt   <= '0;
                first_load  <= 1'b1;
                pass        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Bench for scan_bist_ctrl: chain shift-register model on scan_in/scan_out, a
// scoreboard of expected per-cycle scan controls and end-of-run results.
module tb_scan_bist_ctrl;
    localparam int NC = 2, L = 4, NP = 3, FB = 0;
    localparam int PCW = $clog2(NP + 1);
    localparam logic [31:0] SEED = 32'h00000001, LP = 32'h80200003, MP = 32'h04C11DB7;
    localparam int BUSY_N = NP * (L + 1) + L;
    localparam int D_BUSY = 1024 * 65 + 64;
    localparam int FRC_CYC = 2 * (L + 1) + 3;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? LP : 32'h0);
    endfunction

    function automatic logic [31:0] mstep(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? MP : 32'h0);
    endfunction

    // Expected signature of a full run with the chains looped back
    function automatic logic [31:0] sig_model(input bit frc);
        logic [31:0] lf, ms;
        logic [NC*L-1:0] ch;
        logic [NC-1:0] si, so;
        lf = SEED; ms = '0; ch = '0;
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < L; s++) begin
                si = lf[NC-1:0];
                for (int c = 0; c < NC; c++) so[c] = ch[c*L + L - 1];
                if (frc && p == 2 && s == 3) so[FB] = 1'b1;
                if (p > 0) ms = mstep(ms) ^ 32'(so);
                for (int c = 0; c < NC; c++) ch[c*L +: L] = {ch[c*L +: L-1], si[c]};
                lf = lstep(lf);
            end
        end
        for (int s = 0; s < L; s++) begin
            for (int c = 0; c < NC; c++) so[c] = ch[c*L + L - 1];
            ms = mstep(ms) ^ 32'(so);
            for (int c = 0; c < NC; c++) ch[c*L +: L] = {ch[c*L +: L-1], 1'b0};
        end
        return ms;
    endfunction

    localparam logic [31:0] GOLD = sig_model(1'b0);

    typedef struct packed { logic se; logic [NC-1:0] si; } cyc_t;
    typedef struct packed { logic [31:0] sig; logic pass; logic [15:0] pcnt; } res_t;
    cyc_t cyc_q[$];
    res_t res_q[$];

    logic CK = 1'b0, RST = 1'b1, start = 1'b0, start_d = 1'b0, frc_on = 1'b0;
    logic test_se, busy, done, pass;
    logic [NC-1:0] scan_in, scan_out;
    logic [31:0] signature;
    logic [PCW-1:0] pattern_cnt;
    logic test_se_d, busy_d, done_d, pass_d;
    logic [3:0] scan_in_d;
    logic [3:0] scan_out_d = '0;
    logic [31:0] signature_d;
    logic [10:0] pattern_cnt_d;

    always #5 CK = ~CK;

    scan_bist_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .NUM_PATTERNS(NP), .GOLDEN_SIG(GOLD)) dut (
        .CK(CK), .RST(RST), .start(start), .test_se(test_se), .scan_in(scan_in),
        .scan_out(scan_out), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pattern_cnt(pattern_cnt));

    scan_bist_ctrl dut_d (
        .CK(CK), .RST(RST), .start(start_d), .test_se(test_se_d), .scan_in(scan_in_d),
        .scan_out(scan_out_d), .busy(busy_d), .done(done_d), .pass(pass_d),
        .signature(signature_d), .pattern_cnt(pattern_cnt_d));

    // Scan chains: shift while enabled, hold otherwise
    logic [NC-1:0][L-1:0] chain = '0;
    int bcyc = 0;
    always @(posedge CK) begin
        if (test_se)
            for (int c = 0; c < NC; c++) chain[c] <= {chain[c][L-2:0], scan_in[c]};
        bcyc <= busy ? bcyc + 1 : 0;
    end
    always_comb begin
        for (int c = 0; c < NC; c++) scan_out[c] = chain[c][L-1];
        if (frc_on && bcyc == FRC_CYC) scan_out[FB] = 1'b1;
    end

    int nvec = 0, nerr = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input bit frc, input bit mid, input string tag);
        logic [31:0] lf, es;
        cyc_t cy;
        res_t r;
        int nb;
        cyc_q.delete();
        lf = SEED;
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < L; s++) begin
                cyc_q.push_back('{se: 1'b1, si: lf[NC-1:0]});
                lf = lstep(lf);
            end
            cyc_q.push_back('{se: 1'b0, si: '0});
        end
        for (int s = 0; s < L; s++) cyc_q.push_back('{se: 1'b1, si: '0});
        es = sig_model(frc);
        res_q.push_back('{sig: es, pass: (es == GOLD), pcnt: 16'(NP)});
        frc_on = frc;
        @(negedge CK) start = 1'b1;
        @(negedge CK) start = 1'b0;
        nb = 0;
        for (int k = 0; k < BUSY_N + 10 && !done; k++) begin
            if (busy) begin
                nb++;
                if (cyc_q.size() == 0) chk({tag, "_extra_busy"}, 1, 0);
                else begin
                    cy = cyc_q.pop_front();
                    chk({tag, "_test_se"}, test_se, cy.se);
                    chk({tag, "_scan_in"}, scan_in, cy.si);
                end
            end
            if (mid) begin
                if (k == 5) start = 1'b1;
                if (k == 6) start = 1'b0;
                if (k == 12) start = 1'b1;
            end
            @(negedge CK);
        end
        r = res_q.pop_front();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_busy_len"}, nb, BUSY_N);
        chk({tag, "_signature"}, signature, r.sig);
        chk({tag, "_pass"}, pass, r.pass);
        chk({tag, "_pattern_cnt"}, pattern_cnt, r.pcnt);
        frc_on = 1'b0;
    endtask

    initial begin
        res_t r;
        int nb;
        repeat (3) @(negedge CK);
        chk("rst_test_se", test_se, 0);
        chk("rst_scan_in", scan_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_signature", signature, 0);
        chk("rst_pattern_cnt", pattern_cnt, 0);
        chk("rst_d_outputs", {test_se_d, busy_d, done_d, pass_d, scan_in_d, signature_d, pattern_cnt_d}, 0);
        RST = 1'b0;
        @(negedge CK);
        chk("idle_busy", busy, 0);

        run(1'b0, 1'b0, "t2");
        @(negedge CK);
        chk("t2_idle_done", done, 0);
        chk("t2_keep_sig", signature, GOLD);
        chk("t2_keep_pass", pass, 1);

        run(1'b1, 1'b0, "t3");
        chk("t3_sig_ne_gold", signature != GOLD, 1);
        @(negedge CK);

        @(negedge CK) start = 1'b1;
        @(negedge CK) start = 1'b0;
        repeat (7) @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        chk("t4_rst_test_se", test_se, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_pattern_cnt", pattern_cnt, 0);
        chk("t4_rst_signature", signature, 0);
        RST = 1'b0;
        @(negedge CK);
        chk("t4_idle_busy", busy, 0);
        run(1'b0, 1'b0, "t4");
        @(negedge CK);

        run(1'b0, 1'b1, "t5");
        for (int i = 0; i < 4; i++) begin
            @(negedge CK);
            chk("t5_hold_done", done, 1);
            chk("t5_hold_busy", busy, 0);
        end
        start = 1'b0;
        @(negedge CK);
        chk("t5_release_done", done, 0);
        chk("t5_release_sig", signature, GOLD);
        chk("t5_release_pass", pass, 1);
        @(negedge CK);
        chk("t5_no_retrigger", busy, 0);

        res_q.push_back('{sig: 32'h0, pass: 1'b1, pcnt: 16'd1024});
        @(negedge CK) start_d = 1'b1;
        @(negedge CK) start_d = 1'b0;
        nb = 0;
        for (int k = 0; k < D_BUSY + 10 && !done_d; k++) begin
            if (busy_d) nb++;
            @(negedge CK);
        end
        r = res_q.pop_front();
        chk("t6_done", done_d, 1);
        chk("t6_busy_len", nb, D_BUSY);
        chk("t6_signature", signature_d, r.sig);
        chk("t6_pass", pass_d, r.pass);
        chk("t6_pattern_cnt", pattern_cnt_d, r.pcnt);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
